// File: rtl/inst_buffer_pkg.sv
// Shared types and widths for the dual-issue instruction buffer.
package inst_buffer_pkg;

  localparam int INST_W        = 32;
  localparam int PC_W          = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              is_branch;
  } inst_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push pair, decode-side pop pair and status of the instruction buffer.
// Push handshake: a slot is taken on a rising edge when its valid is high and stall_o
// is low; with stall_o high both slots are dropped and fetch holds them. Pop: decode
// consumes head (and head+1 only together with head) when dispatch_en is high with valid_o.
interface inst_buffer_if #(
  parameter int CNT_W = 6
);
  import inst_buffer_pkg::*;

  logic              flush;
  logic              valid_1_i;
  logic              valid_2_i;
  logic [INST_W-1:0] inst_1_i;
  logic [INST_W-1:0] inst_2_i;
  logic [PC_W-1:0]   pc_1_i;
  logic [PC_W-1:0]   pc_2_i;
  logic              is_branch_1_i;
  logic              is_branch_2_i;
  logic              stall_o;
  logic              dispatch_en_1_i;
  logic              dispatch_en_2_i;
  logic              valid_1_o;
  logic              valid_2_o;
  logic [INST_W-1:0] inst_1_o;
  logic [INST_W-1:0] inst_2_o;
  logic [PC_W-1:0]   pc_1_o;
  logic [PC_W-1:0]   pc_2_o;
  logic              is_branch_1_o;
  logic              is_branch_2_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output flush, valid_1_i, valid_2_i, inst_1_i, inst_2_i, pc_1_i, pc_2_i,
           is_branch_1_i, is_branch_2_i, dispatch_en_1_i, dispatch_en_2_i,
    input  stall_o, valid_1_o, valid_2_o, inst_1_o, inst_2_o, pc_1_o, pc_2_o,
           is_branch_1_o, is_branch_2_o, count_o
  );

  modport slave (
    input  flush, valid_1_i, valid_2_i, inst_1_i, inst_2_i, pc_1_i, pc_2_i,
           is_branch_1_i, is_branch_2_i, dispatch_en_1_i, dispatch_en_2_i,
    output stall_o, valid_1_o, valid_2_o, inst_1_o, inst_2_o, pc_1_o, pc_2_o,
           is_branch_1_o, is_branch_2_o, count_o
  );

endinterface

// File: rtl/inst_buffer_ram.sv
// DEPTH x entry register array with two write ports and two asynchronous read ports.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             we_1,
  input  logic [PTR_W-1:0] waddr_1,
  input  inst_entry_t      wdata_1,
  input  logic             we_2,
  input  logic [PTR_W-1:0] waddr_2,
  input  inst_entry_t      wdata_2,
  input  logic [PTR_W-1:0] raddr_1,
  output inst_entry_t      rdata_1,
  input  logic [PTR_W-1:0] raddr_2,
  output inst_entry_t      rdata_2
);

  inst_entry_t mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (we_1) mem[waddr_1] <= wdata_1;
    if (we_2) mem[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction FIFO: pointer/count control with in-order pop of up to two entries.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = 5,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  inst_buffer_if.slave bus
);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic        stall;
  logic        valid_1;
  logic        valid_2;
  logic        push_ok;
  logic [1:0]  npush;
  logic [1:0]  npush_eff;
  logic [1:0]  npop;

  inst_entry_t in_1;
  inst_entry_t in_2;
  inst_entry_t wdata_1;
  inst_entry_t rd_1;
  inst_entry_t rd_2;

  // Occupancy is tracked explicitly; pointers alone cannot tell full from empty.
  assign stall   = count_q > CNT_W'(DEPTH - 2);
  assign valid_1 = count_q != '0;
  assign valid_2 = count_q > CNT_W'(1);

  assign push_ok   = !stall && !bus.flush;
  assign npush     = {1'b0, bus.valid_1_i} + {1'b0, bus.valid_2_i};
  assign npush_eff = push_ok ? npush : 2'd0;
  assign npop      = {1'b0, bus.dispatch_en_1_i & valid_1}
                   + {1'b0, bus.dispatch_en_1_i & bus.dispatch_en_2_i & valid_2};

  assign in_1 = '{pc: bus.pc_1_i, inst: bus.inst_1_i, is_branch: bus.is_branch_1_i};
  assign in_2 = '{pc: bus.pc_2_i, inst: bus.inst_2_i, is_branch: bus.is_branch_2_i};

  // Compaction: a lone slot 2 lands at tail through write port 1.
  assign wdata_1 = bus.valid_1_i ? in_1 : in_2;

  inst_buffer_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_1    (push_ok && (bus.valid_1_i || bus.valid_2_i)),
    .waddr_1 (tail_q),
    .wdata_1 (wdata_1),
    .we_2    (push_ok && bus.valid_1_i && bus.valid_2_i),
    .waddr_2 (tail_q + PTR_W'(1)),
    .wdata_2 (in_2),
    .raddr_1 (head_q),
    .rdata_1 (rd_1),
    .raddr_2 (head_q + PTR_W'(1)),
    .rdata_2 (rd_2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(npop);
      tail_q  <= tail_q + PTR_W'(npush_eff);
      count_q <= count_q + CNT_W'(npush_eff) - CNT_W'(npop);
    end
  end

  assign bus.stall_o       = stall;
  assign bus.count_o       = count_q;
  assign bus.valid_1_o     = valid_1;
  assign bus.valid_2_o     = valid_2;
  assign bus.pc_1_o        = valid_1 ? rd_1.pc        : '0;
  assign bus.inst_1_o      = valid_1 ? rd_1.inst      : '0;
  assign bus.is_branch_1_o = valid_1 ? rd_1.is_branch : 1'b0;
  assign bus.pc_2_o        = valid_2 ? rd_2.pc        : '0;
  assign bus.inst_2_o      = valid_2 ? rd_2.inst      : '0;
  assign bus.is_branch_2_o = valid_2 ? rd_2.is_branch : 1'b0;

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: queue-based reference model, per-cycle expected snapshots, monitor compare.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;
  localparam int SW    = CNT_W + 3 + 2 * (PC_W + INST_W + 1);

  logic clk;
  logic rst;

  inst_buffer_if #(.CNT_W(CNT_W)) bus ();

  inst_buffer #(.DEPTH(DEPTH), .PTR_W(5), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model & scoreboard ----------------
  inst_entry_t     model_q[$];
  logic [SW-1:0]   exp_q[$];
  int              n_vec  = 0;
  int              n_fail = 0;
  int              cycle  = 0;

  function automatic inst_entry_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic br);
    inst_entry_t e;
    e.pc = pc;
    e.inst = inst;
    e.is_branch = br;
    return e;
  endfunction

  function automatic logic [SW-1:0] model_snap();
    inst_entry_t e1;
    inst_entry_t e2;
    int n;
    n  = model_q.size();
    e1 = '0;
    e2 = '0;
    if (n >= 1) e1 = model_q[0];
    if (n >= 2) e2 = model_q[1];
    return {CNT_W'(n), ((DEPTH - n) < 2), (n >= 1), (n >= 2),
            e1.pc, e1.inst, e1.is_branch, e2.pc, e2.inst, e2.is_branch};
  endfunction

  function automatic logic [SW-1:0] dut_snap();
    return {bus.count_o, bus.stall_o, bus.valid_1_o, bus.valid_2_o,
            bus.pc_1_o, bus.inst_1_o, bus.is_branch_1_o,
            bus.pc_2_o, bus.inst_2_o, bus.is_branch_2_o};
  endfunction

  // ---------------- driver ----------------
  // One call = one clock cycle of stimulus; expected view of the current state is queued first.
  task automatic step(input logic v1, input logic v2, input logic de1, input logic de2,
                      input logic fl, input inst_entry_t e1, input inst_entry_t e2);
    int n;
    int npop;
    bit full_ish;
    @(negedge clk);
    cycle++;
    exp_q.push_back(model_snap());
    bus.valid_1_i       = v1;
    bus.valid_2_i       = v2;
    bus.dispatch_en_1_i = de1;
    bus.dispatch_en_2_i = de2;
    bus.flush           = fl;
    bus.pc_1_i          = e1.pc;
    bus.inst_1_i        = e1.inst;
    bus.is_branch_1_i   = e1.is_branch;
    bus.pc_2_i          = e2.pc;
    bus.inst_2_i        = e2.inst;
    bus.is_branch_2_i   = e2.is_branch;
    n        = model_q.size();
    full_ish = (DEPTH - n) < 2;
    if (fl) begin
      model_q.delete();
    end else begin
      npop = 0;
      if (de1 && n >= 1) npop = 1;
      if (de1 && de2 && n >= 2) npop = 2;
      repeat (npop) void'(model_q.pop_front());
      if (!full_ish) begin
        if (v1) model_q.push_back(e1);
        if (v2) model_q.push_back(e2);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push_pair(input logic [31:0] pc);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(pc, $urandom, 1'($urandom_range(0, 1))),
         mk(pc + 32'd4, $urandom, 1'($urandom_range(0, 1))));
  endtask

  task automatic pop_two();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [SW-1:0] exp_v;
    logic [SW-1:0] act_v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = dut_snap();
        n_vec++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL snapshot cycle %0d: got %h, expected %h", cycle, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.valid_1_i = 1'b0;
    bus.valid_2_i = 1'b0;
    bus.dispatch_en_1_i = 1'b0;
    bus.dispatch_en_2_i = 1'b0;
    bus.pc_1_i = '0;
    bus.pc_2_i = '0;
    bus.inst_1_i = '0;
    bus.inst_2_i = '0;
    bus.is_branch_1_i = 1'b0;
    bus.is_branch_2_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state, then a single push
    idle();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h1c000000, 32'h02800000, 1'b0), '0);
    idle();
    // lone slot 2 goes to tail
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, mk(32'h1c000040, 32'h00112233, 1'b1));
    idle();
    pop_two();

    // fill to 32, then a dropped pair
    for (int i = 0; i < 16; i++) push_pair(32'h1c001000 + 32'(i * 8));
    push_pair(32'h1c002000);
    idle();
    // full + pop two + push: push dropped, count 30; then a pair is accepted
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, mk(32'h1c003000, 32'hdeadbeef, 1'b1),
         mk(32'h1c003004, 32'hcafef00d, 1'b0));
    push_pair(32'h1c004000);
    idle();

    // wrap: head=0, fill 31, drain to head=30, push across 31->0
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 15; i++) push_pair(32'h1c005000 + 32'(i * 8));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h1c005078, 32'h0000aaaa, 1'b0), '0);
    repeat (15) pop_two();
    for (int i = 0; i < 8; i++) push_pair(32'h1c006000 + 32'(i * 8));
    repeat (9) pop_two();
    idle();

    // flush with count=7 plus concurrent push/pop
    for (int i = 0; i < 3; i++) push_pair(32'h1c007000 + 32'(i * 8));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h1c007018, 32'h0000bbbb, 1'b1), '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(32'h1c008000, 32'h11111111, 1'b0),
         mk(32'h1c008004, 32'h22222222, 1'b1));
    idle();

    // asynchronous reset between edges
    push_pair(32'h1c009000);
    push_pair(32'h1c009008);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.count_o, bus.stall_o, bus.valid_1_o, bus.valid_2_o, bus.pc_1_o, bus.pc_2_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d valid1=%b valid2=%b pc1=%h, expected all zero",
               bus.count_o, bus.valid_1_o, bus.valid_2_o, bus.pc_1_o);
    end
    model_q.delete();
    #1;
    rst = 1'b1;
    idle();
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 32'h0fffffff), 2'b00, 2'b00};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 63) == 0),
           mk(pc, $urandom, 1'($urandom_range(0, 1))),
           mk(pc + 32'd4, $urandom, 1'($urandom_range(0, 1))));
    end
    idle();
    idle();

    @(negedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-issue instruction FIFO between the fetch stage and the decode stage.
- Accepts up to two fetched instruction bundles per cycle (inst, pc, is_branch) and holds them in a circular buffer.
- Presents the two oldest entries to decode and pops 0, 1 or 2 entries per cycle, in order.
- Back-pressures fetch when it cannot absorb a full pair; fully cleared on flush.

Parameters:
- DEPTH, 32: entry count; power of two, minimum 4.
- PTR_W, 5: log2(DEPTH); pointer width.
- CNT_W, 6: PTR_W+1; occupancy counter width (holds 0..DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- valid_1_i  in  1  push slot 1 valid.
- valid_2_i  in  1  push slot 2 valid.
- inst_1_i / inst_2_i  in  32  fetched instructions.
- pc_1_i / pc_2_i  in  32  instruction PCs.
- is_branch_1_i / is_branch_2_i  in  1  predecode branch flags.
- stall_o  out  1  to fetch: buffer cannot take a pair this cycle.
- dispatch_en_1_i  in  1  decode consumes entry 1 this cycle.
- dispatch_en_2_i  in  1  decode consumes entry 2 this cycle.
- valid_1_o / valid_2_o  out  1  head / head+1 entries valid.
- inst_1_o / inst_2_o  out  32  head / head+1 instructions.
- pc_1_o / pc_2_o  out  32  head / head+1 PCs.
- is_branch_1_o / is_branch_2_o  out  1  head / head+1 branch flags.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous)
  - head, tail and count clear to 0.
  - All outputs read 0; stall_o=0.
  - Storage contents need not be cleared.
- Entry format: {pc[31:0], inst[31:0], is_branch}.
- Storage: circular array; head/tail wrap modulo DEPTH. count is tracked explicitly; full/empty are never derived from pointer equality.
- stall_o is combinational from registered state: stall_o = (DEPTH - count) < 2.
- Push
  - Accepted only when stall_o=0; otherwise both push slots are dropped, and fetch must hold its pair.
  - npush = valid_1_i + valid_2_i.
  - Valid slots are compacted: slot 1 is written first. If only valid_2_i is set, it goes to tail.
  - tail += npush.
- Pop
  - npop = dispatch_en_1_i & valid_1_o, plus dispatch_en_2_i & dispatch_en_1_i & valid_2_o.
  - dispatch_en_2_i without dispatch_en_1_i is ignored (in-order).
  - head += npop.
- Simultaneous push and pop: count_next = count + npush - npop.
  - Pop acts on pre-edge contents. No bypass: a pushed entry first appears on outputs the cycle after its write.
- Read outputs are combinational from storage at head and head+1 (mod DEPTH).
  - valid_1_o = (count >= 1); valid_2_o = (count >= 2).
  - Data fields of an invalid output are forced to 0.
- Flush has priority over push and pop in the same cycle.
  - head, tail and count go to 0; concurrent push and pop are discarded.
  - valid_*_o = 0 the next cycle.
- Wrap-around: writes to index DEPTH-1 and 0 in the same cycle are legal. A pair spanning the wrap is read correctly.
- Latency: push-to-visible is 1 cycle; empty-buffer fetch-to-decode is 1 cycle.
- An active-low reset asserted mid-operation clears state immediately, without waiting for clk.

Decomposition:
- Shared package:
  - INST_W = 32.
  - PC_W = 32.
  - Packed typedef inst_entry_t {pc, inst, is_branch}.
  - Default DEPTH.
- Top level: pointer/count control and push/pop arithmetic.
- One natural sub-module, inst_buffer_ram: dual-write, dual-read DEPTH x entry register array, with write-enable per port and asynchronous read.

Test Plan:
- Reset then idle → valid_1_o=0, valid_2_o=0, stall_o=0, count_o=0.
- Single push of pc=0x1c000000, inst=0x02800000, is_branch=0 → next cycle valid_1_o=1, pc_1_o=0x1c000000, valid_2_o=0, count_o=1.
- Push pairs (pc+0, pc+4) for 16 cycles, no dispatch → count_o=32 and stall_o=1.
  - A further push with valid_1_i=valid_2_i=1 is dropped; count_o stays 32.
- Full buffer with dispatch_en_1_i=dispatch_en_2_i=1 and a concurrent push → push is dropped (stall_o=1); count_o=30.
  - Next cycle stall_o=0, and a new pair is accepted in order.
- Fill to 31, drain so head=30, then push across the wrap → pc_1_o/pc_2_o come out in order across index 31→0 with no duplicate or lost entries.
- flush asserted with count=7 and a concurrent push/pop → next cycle count_o=0, valid_*_o=0; the pushed pair is absent.
  - rst pulsed low between edges clears outputs asynchronously.
